// File: rtl/fifo_priority_mc_if.sv
// Handshake bundle for fifo_priority_mc.
//   master: producer/consumer side (drives data_in, vld_i, rdy_i)
//   slave : the buffer itself (drives rdy_o, data_out, vld_o, count_o)
// Signals:
//   data_in  [DW]  input word, priority in its top $clog2(NPRIO) bits
//   vld_i / rdy_o  input handshake
//   data_out [DW]  head word of the granted class, zero when idle
//   vld_o / rdy_i  output handshake
//   count_o  [CW]  total stored words
interface fifo_priority_mc_if #(
    parameter int unsigned DW    = 33,
    parameter int unsigned DEPTH = 5,
    parameter int unsigned NPRIO = 4
);
    localparam int unsigned CW = $clog2(NPRIO * DEPTH + 1);

    logic [DW-1:0] data_in;
    logic          vld_i;
    logic          rdy_o;
    logic [DW-1:0] data_out;
    logic          vld_o;
    logic          rdy_i;
    logic [CW-1:0] count_o;

    modport master (
        output data_in, vld_i, rdy_i,
        input  rdy_o, data_out, vld_o, count_o
    );

    modport slave (
        input  data_in, vld_i, rdy_i,
        output rdy_o, data_out, vld_o, count_o
    );
endinterface

// File: rtl/fifo_priority_mc.sv
// Multi-class priority buffer. Words are sorted by their top priority bits into NPRIO
// circular queues of DEPTH entries; the output presents the head of the highest non-empty
// class. A stalled output (vld_o && !rdy_i) locks the grant until that word is popped.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  fifo_priority_mc_if.slave (data_in/vld_i/rdy_o in, data_out/vld_o/rdy_i out,
//        count_o total occupancy)
// Optional build macro FIFO_PRIO_AGING_EN: per-class age counters; a class whose age hits
// AGE_LIMIT (parameter present only in that build) wins an unlocked grant.
module fifo_priority_mc #(
    parameter int unsigned DW        = 33,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned NPRIO     = 4
`ifdef FIFO_PRIO_AGING_EN
    ,
    parameter int unsigned AGE_LIMIT = 8
`endif
) (
    input logic               clk,
    input logic               rst,
    fifo_priority_mc_if.slave bus
);
    localparam int unsigned PW = $clog2(NPRIO);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(NPRIO * DEPTH + 1);

    logic [DW-1:0]    mem_q [NPRIO][DEPTH];
    logic [AW-1:0]    rd_q  [NPRIO];
    logic [AW-1:0]    rd_d  [NPRIO];
    logic [AW-1:0]    wr_q  [NPRIO];
    logic [AW-1:0]    wr_d  [NPRIO];
    logic [OW-1:0]    cnt_q [NPRIO];
    logic [OW-1:0]    cnt_d [NPRIO];
    logic [CW-1:0]    count_q, count_d;
    logic             lock_q, lock_d;
    logic [PW-1:0]    lock_cls_q, lock_cls_d;

    logic [NPRIO-1:0] not_empty;
    logic [NPRIO-1:0] push_hit;
    logic [NPRIO-1:0] pop_hit;
    logic [PW-1:0]    push_cls;
    logic [PW-1:0]    sel;
    logic [PW-1:0]    grant;
    logic             any_valid;
    logic             ready;
    logic             push;
    logic             pop;

`ifdef FIFO_PRIO_AGING_EN
    localparam int unsigned AGW = $clog2(AGE_LIMIT + 1);
    logic [AGW-1:0]   age_q [NPRIO];
    logic [AGW-1:0]   age_d [NPRIO];
`endif

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status comes from registered counters only: no bypass, no full-while-popping relief.
    always_comb begin
        not_empty = '0;
        for (int c = 0; c < NPRIO; c++) begin
            not_empty[c] = (cnt_q[c] != '0);
        end
    end

    always_comb begin
        sel = '0;
        for (int c = 0; c < NPRIO; c++) begin
            if (not_empty[c]) sel = PW'(c);
        end
`ifdef FIFO_PRIO_AGING_EN
        for (int c = 0; c < NPRIO; c++) begin
            if (not_empty[c] && age_q[c] == AGW'(AGE_LIMIT)) sel = PW'(c);
        end
`endif
    end

    assign grant     = lock_q ? lock_cls_q : sel;
    assign any_valid = |not_empty;
    assign pop       = any_valid & bus.rdy_i;
    assign push_cls  = bus.data_in[DW-1 -: PW];

    // Encodings beyond NPRIO-1 (non power-of-two NPRIO) are never ready.
    always_comb begin
        ready = 1'b0;
        for (int c = 0; c < NPRIO; c++) begin
            if (push_cls == PW'(c)) ready = (cnt_q[c] != OW'(DEPTH));
        end
    end

    assign push = bus.vld_i & ready;

    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        for (int c = 0; c < NPRIO; c++) begin
            push_hit[c] = push && (push_cls == PW'(c));
            pop_hit[c]  = pop && (grant == PW'(c));
        end
    end

    always_comb begin
        for (int c = 0; c < NPRIO; c++) begin
            rd_d[c]  = rd_q[c];
            wr_d[c]  = wr_q[c];
            cnt_d[c] = cnt_q[c];
            if (push_hit[c]) wr_d[c] = wrap_inc(wr_q[c]);
            if (pop_hit[c])  rd_d[c] = wrap_inc(rd_q[c]);
            if (push_hit[c] && !pop_hit[c]) begin
                cnt_d[c] = cnt_q[c] + 1'b1;
            end else if (pop_hit[c] && !push_hit[c]) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end
        end
        count_d    = count_q + CW'(push) - CW'(pop);
        // Stalled: capture the presented class; popping or idle: release.
        lock_d     = any_valid & ~bus.rdy_i;
        lock_cls_d = grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NPRIO; c++) begin
                rd_q[c]  <= '0;
                wr_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_cls_q <= '0;
        end else begin
            for (int c = 0; c < NPRIO; c++) begin
                rd_q[c]  <= rd_d[c];
                wr_q[c]  <= wr_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_cls_q <= lock_cls_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NPRIO; c++) begin
            if (!rst && push_hit[c]) mem_q[c][wr_q[c]] <= bus.data_in;
        end
    end

`ifdef FIFO_PRIO_AGING_EN
    // Age counts pops that bypass a waiting class; reset by being served or draining.
    always_comb begin
        for (int c = 0; c < NPRIO; c++) begin
            age_d[c] = age_q[c];
            if (!not_empty[c]) begin
                age_d[c] = '0;
            end else if (pop) begin
                if (grant == PW'(c)) begin
                    age_d[c] = '0;
                end else if (age_q[c] != AGW'(AGE_LIMIT)) begin
                    age_d[c] = age_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NPRIO; c++) begin
            if (rst) age_q[c] <= '0;
            else     age_q[c] <= age_d[c];
        end
    end
`endif

    assign bus.rdy_o    = ready;
    assign bus.vld_o    = any_valid;
    assign bus.data_out = any_valid ? mem_q[grant][rd_q[grant]] : '0;
    assign bus.count_o  = count_q;
endmodule

// File: tb/tb_fifo_priority_mc.sv
module tb_fifo_priority_mc;
    localparam int DW        = 33;
    localparam int DEPTH     = 5;
    localparam int NPRIO     = 4;
    localparam int PW        = 2;
    localparam int AGE_LIMIT = 8;

    logic clk;
    logic rst;

    fifo_priority_mc_if #(.DW(DW), .DEPTH(DEPTH), .NPRIO(NPRIO)) bus ();

    fifo_priority_mc #(.DW(DW), .DEPTH(DEPTH), .NPRIO(NPRIO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int p, input int v);
        logic [DW-1:0] w;
        w = DW'(v);
        w[DW-1 -: PW] = PW'(p);
        return w;
    endfunction

    // Reference model: one queue per class, plus lock and age bookkeeping.
    logic [DW-1:0] mq [NPRIO][$];
    bit            m_lock;
    int            m_lock_cls;
    int            m_age [NPRIO];
    bit            model_ok = 1'b0;

    logic [DW-1:0] pop_log [$];
    bit            log_en = 1'b0;

    function automatic bit m_vld();
        for (int c = 0; c < NPRIO; c++) if (mq[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_grant();
        int g;
        g = 0;
        if (m_lock) return m_lock_cls;
        for (int c = 0; c < NPRIO; c++) if (mq[c].size() != 0) g = c;
`ifdef FIFO_PRIO_AGING_EN
        for (int c = 0; c < NPRIO; c++)
            if (mq[c].size() != 0 && m_age[c] == AGE_LIMIT) g = c;
`endif
        return g;
    endfunction

    function automatic bit m_rdy(input logic [DW-1:0] d);
        int p;
        p = int'(d[DW-1 -: PW]);
        return (p < NPRIO) && (mq[p].size() < DEPTH);
    endfunction

    function automatic int m_total();
        int t;
        t = 0;
        for (int c = 0; c < NPRIO; c++) t += mq[c].size();
        return t;
    endfunction

    int            mg;
    bit            mv;
    bit            dpush;
    bit            dpop;
    logic [DW-1:0] exp_data;

    // Compare the DUT against the model, then advance the model by the inputs that the
    // next rising edge will sample.
    always @(negedge clk) begin
        mg = m_grant();
        mv = m_vld();
        if (model_ok) begin
            exp_data = '0;
            if (mv) exp_data = mq[mg][0];
            chk("vld_o", 64'(bus.vld_o), 64'(mv));
            chk("data_out", 64'(bus.data_out), 64'(exp_data));
            chk("count_o", 64'(bus.count_o), 64'(m_total()));
            chk("rdy_o", 64'(bus.rdy_o), 64'(m_rdy(bus.data_in)));
        end
        if (log_en && bus.vld_o && bus.rdy_i) pop_log.push_back(bus.data_out);
        if (rst) begin
            for (int c = 0; c < NPRIO; c++) begin
                mq[c].delete();
                m_age[c] = 0;
            end
            m_lock     = 1'b0;
            m_lock_cls = 0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            dpop  = mv && bus.rdy_i;
            dpush = bus.vld_i && m_rdy(bus.data_in);
`ifdef FIFO_PRIO_AGING_EN
            for (int c = 0; c < NPRIO; c++) begin
                if (mq[c].size() == 0) m_age[c] = 0;
                else if (dpop) begin
                    if (c == mg) m_age[c] = 0;
                    else if (m_age[c] < AGE_LIMIT) m_age[c]++;
                end
            end
`endif
            if (dpop) void'(mq[mg].pop_front());
            if (dpush) mq[int'(bus.data_in[DW-1 -: PW])].push_back(bus.data_in);
            m_lock     = mv && !bus.rdy_i;
            m_lock_cls = mg;
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
        bus.vld_i   = v;
        bus.data_in = d;
        bus.rdy_i   = r;
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_order [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.vld_i   = 1'b0;
        bus.data_in = '0;
        bus.rdy_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("reset vld_o", 64'(bus.vld_o), 64'h0);
        chk("reset data_out", 64'(bus.data_out), 64'h0);
        chk("reset count_o", 64'(bus.count_o), 64'h0);
        chk("reset rdy_o", 64'(bus.rdy_o), 64'h1);

        // Single word, one-cycle latency
        drive(1'b1, 33'h0_0000_0001, 1'b0);
        chk("latency vld_o", 64'(bus.vld_o), 64'h1);
        chk("latency data_out", 64'(bus.data_out), 64'h1);
        drive(1'b0, '0, 1'b1);
        chk("single pop count", 64'(bus.count_o), 64'h0);

        // Priority order. The class-0 word is presented while stalled, so the lock keeps
        // it first; the rest drain strictly by class.
        drive(1'b1, mk(0, 'h10), 1'b0);
        drive(1'b1, mk(3, 'h11), 1'b0);
        drive(1'b1, mk(1, 'h12), 1'b0);
        drive(1'b1, mk(2, 'h13), 1'b0);
        exp_order[0] = 33'h0_0000_0010;
        exp_order[1] = 33'h1_8000_0011;
        exp_order[2] = 33'h1_0000_0013;
        exp_order[3] = 33'h0_8000_0012;
        for (int i = 0; i < 4; i++) begin
            chk("prio count", 64'(bus.count_o), 64'(4 - i));
            chk("prio order", 64'(bus.data_out), 64'(exp_order[i]));
            drive(1'b0, '0, 1'b1);
        end
        chk("prio drained", 64'(bus.count_o), 64'h0);

        // Lock under stall
        drive(1'b1, mk(1, 'h21), 1'b0);
        drive(1'b1, mk(3, 'h23), 1'b0);
        chk("lock hold 1", 64'(bus.data_out), 64'h0_8000_0021);
        drive(1'b0, '0, 1'b0);
        chk("lock hold 2", 64'(bus.data_out), 64'h0_8000_0021);
        drive(1'b0, '0, 1'b1);
        chk("lock next", 64'(bus.data_out), 64'h1_8000_0023);
        drive(1'b0, '0, 1'b1);
        chk("lock drained", 64'(bus.count_o), 64'h0);

        // Per-class full
        for (int i = 0; i < DEPTH; i++) drive(1'b1, mk(2, 'h30 + i), 1'b0);
        chk("full count", 64'(bus.count_o), 64'(DEPTH));
        bus.data_in = mk(2, 0);
        #1;
        chk("full rdy class2", 64'(bus.rdy_o), 64'h0);
        bus.data_in = mk(0, 0);
        #1;
        chk("full rdy class0", 64'(bus.rdy_o), 64'h1);
        drive(1'b1, mk(2, 'h35), 1'b1);
        chk("full push refused", 64'(bus.count_o), 64'(DEPTH - 1));
        chk("full next head", 64'(bus.data_out), 64'h1_0000_0031);
        for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, '0, 1'b1);
        chk("full drained", 64'(bus.count_o), 64'h0);

        // Wrap-around streaming through class 0
        pop_log.delete();
        log_en = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) drive(1'b1, mk(0, 'h100 + i), 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        log_en = 1'b0;
        chk("wrap pop count", 64'(pop_log.size()), 64'(3 * DEPTH));
        for (int i = 0; i < pop_log.size(); i++)
            chk("wrap data", 64'(pop_log[i]), 64'('h100 + i));

        // Aging: class 0 waits while class 3 is refilled every cycle
        pop_log.delete();
        log_en = 1'b1;
        drive(1'b1, mk(3, 'h50), 1'b0);
        drive(1'b1, mk(0, 'h40), 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, mk(3, 'h51 + i), 1'b1);
        for (int k = 0; k < 20 && bus.vld_o; k++) drive(1'b0, '0, 1'b1);
        chk("aging drain bound", 64'(bus.vld_o), 64'h0);
        log_en = 1'b0;
        chk("aging pop count", 64'(pop_log.size()), 64'd12);
        if (pop_log.size() == 12) begin
`ifdef FIFO_PRIO_AGING_EN
            chk("aging ninth pop", 64'(pop_log[8]), 64'h0_0000_0040);
            chk("aging last pop", 64'(pop_log[11]), 64'h1_8000_005A);
`else
            chk("starve ninth pop", 64'(pop_log[8]), 64'h1_8000_0058);
            chk("starve last pop", 64'(pop_log[11]), 64'h0_0000_0040);
`endif
        end

        // Reset mid-traffic discards contents and ignores the concurrent push
        drive(1'b1, mk(1, 'h77), 1'b0);
        rst = 1'b1;
        drive(1'b1, mk(2, 'h78), 1'b1);
        rst = 1'b0;
        bus.vld_i = 1'b0;
        #1;
        chk("rst vld_o", 64'(bus.vld_o), 64'h0);
        chk("rst count_o", 64'(bus.count_o), 64'h0);
        drive(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
